// File: rtl/tcdm_apb_initiator_pkg.sv
// tcdm_apb_pkg: FSM state type, abort read data and timeout counter sizing for tcdm_apb_initiator.
package tcdm_apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/tcdm_apb_initiator_if.sv
// APB_BUS: APB3 signal bundle with Master and Slave views.
interface APB_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic                  pready;
    logic                  pslverr;
    modport Master (output paddr, pwdata, pwrite, psel, penable, input prdata, pready, pslverr);
    modport Slave (input paddr, pwdata, pwrite, psel, penable, output prdata, pready, pslverr);
endinterface

// File: rtl/tcdm_apb_initiator.sv
// tcdm_apb_initiator: single-outstanding TCDM request port to APB3 master bridge.
// Defining APB_TIMEOUT_EN adds an ACCESS-phase timeout that aborts with ERR_RDATA.
module tcdm_apb_initiator
    import tcdm_apb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic [APB_ADDR_WIDTH-1:0]   add_i,
    input  logic                        wen_i,
    input  logic [APB_DATA_WIDTH/8-1:0] be_i,
    input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
    output logic                        gnt_o,
    output logic                        r_valid_o,
    output logic [APB_DATA_WIDTH-1:0]   r_rdata_o,
    output logic                        r_opc_o,
    APB_BUS.Master                      apb_master
);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    state_e                    state_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      pwrite_q;
    logic                      opc_q;
    logic                      access;
    logic                      take;
    logic                      done;
    logic                      unused_be;
    assign access    = state_q == ACCESS;
    assign take      = req_i && (state_q == IDLE || state_q == RESP);
    assign unused_be = ^be_i;
`ifdef APB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;
    assign timeout = access && !apb_master.pready && cnt_q == CNT_W'(TIMEOUT_CYCLES);
    assign done    = access && (apb_master.pready || timeout);
`else
    logic unused_cfg;
    assign unused_cfg = ^CNT_W'(TIMEOUT_CYCLES);
    assign done       = access && apb_master.pready;
`endif
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            opc_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            if (take) begin
                paddr_q  <= add_i;
                pwdata_q <= wdata_i;
                pwrite_q <= !wen_i;
            end
            if (done) begin
`ifdef APB_TIMEOUT_EN
                rdata_q <= timeout ? APB_DATA_WIDTH'(ERR_RDATA) : pwrite_q ? '0 : apb_master.prdata;
                opc_q   <= timeout || apb_master.pslverr;
`else
                rdata_q <= pwrite_q ? '0 : apb_master.prdata;
                opc_q   <= apb_master.pslverr;
`endif
            end
`ifdef APB_TIMEOUT_EN
            // Counts stalled ACCESS cycles; held at zero everywhere else so entry starts clean.
            cnt_q <= access ? cnt_q + 1'b1 : '0;
`endif
            state_q <= take ? SETUP : state_q == SETUP ? ACCESS : done ? RESP : access ? ACCESS : IDLE;
        end
    end
    assign gnt_o              = done;
    assign r_valid_o          = state_q == RESP;
    assign r_rdata_o          = rdata_q;
    assign r_opc_o            = opc_q;
    assign apb_master.psel    = state_q == SETUP || access;
    assign apb_master.penable = access;
    assign apb_master.paddr   = paddr_q;
    assign apb_master.pwdata  = pwdata_q;
    assign apb_master.pwrite  = pwrite_q;
endmodule

// File: tb/tb_tcdm_apb_initiator.sv
// tb_tcdm_apb_initiator: randomized cycle-schedule check of tcdm_apb_initiator against latency rules.
module tb_tcdm_apb_initiator;
    import tcdm_apb_pkg::*;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int NT = 40;
    localparam int NC = 1200;
    typedef struct {
        logic          req, wen, rdy, err, gnt, rv, sel, en, pwr, opc;
        logic [31:0]   addr, wd, prd, rd, paddr, pwd;
    } cyc_t;
    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_i = 1'b0;
    logic          wen_i = 1'b0;
    logic [AW-1:0] add_i = '0;
    logic [DW/8-1:0] be_i = '1;
    logic [DW-1:0] wdata_i = '0;
    logic          gnt_o, r_valid_o, r_opc_o;
    logic [DW-1:0] r_rdata_o;
    cyc_t          tab [NC];
    int            n_cyc;
    int            cur;
    int            n_chk = 0;
    int            n_err = 0;
    APB_BUS #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();
    tcdm_apb_initiator #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .req_i(req_i),
        .add_i(add_i),
        .wen_i(wen_i),
        .be_i(be_i),
        .wdata_i(wdata_i),
        .gnt_o(gnt_o),
        .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o),
        .r_opc_o(r_opc_o),
        .apb_master(apb)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d: got %0h, expected %0h", tag, cur, got, exp);
        end
    endtask
    // Each transaction: req at R, SETUP at R+1, gnt at R+2+waits, response at gnt+1.
    task automatic build();
        int c = 0;
        for (int i = 0; i < NC; i++) begin
            tab[i] = '{default: '0};
            tab[i].addr = $urandom;
            tab[i].wd   = $urandom;
            tab[i].prd  = $urandom;
            tab[i].wen  = 1'($urandom);
            tab[i].rdy  = 1'($urandom);
            tab[i].err  = 1'($urandom);
        end
        for (int k = 0; k < NT; k++) begin
            int gap, w, we, g;
            logic [31:0] a, d, p;
            logic rd_n, e, ab;
            gap  = $urandom_range(0, 3);
            w    = $urandom_range(0, 10);
            a    = $urandom;
            d    = $urandom;
            p    = $urandom;
            rd_n = 1'($urandom);
            e    = $urandom_range(0, 3) == 0;
            if (k == 0) begin gap = 1; a = 32'h1A10_2000; rd_n = 1; p = 32'h1234_5678; w = 0; e = 0; end
            if (k == 1) begin gap = 2; rd_n = 0; d = 32'hCAFE_F00D; w = 3; e = 0; end
            if (k == 2) begin gap = 1; rd_n = 1; w = 1; e = 1; end
            if (k >= 3 && k <= 6) begin gap = (k == 3) ? 1 : 0; w = 0; end
            ab = 1'b0;
`ifdef APB_TIMEOUT_EN
            if (w > TO) ab = 1'b1;
`endif
            we = ab ? TO : w;
            c  = c + gap;
            g  = c + 2 + we;
            for (int i = c; i <= g; i++) begin
                tab[i].req  = 1'b1;
                tab[i].addr = a;
                tab[i].wen  = rd_n;
                tab[i].wd   = d;
                if (i > c) begin
                    tab[i].sel   = 1'b1;
                    tab[i].paddr = a;
                    tab[i].pwr   = !rd_n;
                    tab[i].pwd   = d;
                end
                if (i > c + 1) begin
                    tab[i].en  = 1'b1;
                    tab[i].rdy = 1'b0;
                end
            end
            tab[g].rdy   = !ab;
            tab[g].prd   = p;
            tab[g].err   = e;
            tab[g].gnt   = 1'b1;
            tab[g+1].rv  = 1'b1;
            tab[g+1].rd  = ab ? ERR_RDATA : rd_n ? p : 32'h0;
            tab[g+1].opc = ab | e;
            if (ab) tab[g+1].rdy = 1'b1;
            c = g + 1;
        end
        n_cyc = c + 3;
    endtask
    initial begin
        build();
        apb.pready  = 1'b0;
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
        cur = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_opc", r_opc_o, 0);
        chk("rst_r_rdata", r_rdata_o, 0);
        chk("rst_psel", apb.psel, 0);
        chk("rst_penable", apb.penable, 0);
        chk("rst_pwrite", apb.pwrite, 0);
        chk("rst_paddr", apb.paddr, 0);
        chk("rst_pwdata", apb.pwdata, 0);
        @(negedge clk) rst_ni = 1'b1;
        for (int i = 0; i < n_cyc; i++) begin
            @(posedge clk);
            #1;
            cur         = i;
            req_i       = tab[i].req;
            add_i       = tab[i].addr;
            wen_i       = tab[i].wen;
            wdata_i     = tab[i].wd;
            be_i        = 4'($urandom);
            apb.pready  = tab[i].rdy;
            apb.prdata  = tab[i].prd;
            apb.pslverr = tab[i].err;
            #1;
            chk("gnt", gnt_o, tab[i].gnt);
            chk("r_valid", r_valid_o, tab[i].rv);
            chk("psel", apb.psel, tab[i].sel);
            chk("penable", apb.penable, tab[i].en);
            if (tab[i].sel) begin
                chk("paddr", apb.paddr, tab[i].paddr);
                chk("pwrite", apb.pwrite, tab[i].pwr);
                chk("pwdata", apb.pwdata, tab[i].pwd);
            end
            if (tab[i].rv) begin
                chk("r_rdata", r_rdata_o, tab[i].rd);
                chk("r_opc", r_opc_o, tab[i].opc);
            end
        end
        // Reset in the middle of a stalled ACCESS, with PREADY rising at the same moment.
        cur = n_cyc;
        @(posedge clk);
        #1;
        req_i = 1'b1;
        wen_i = 1'b1;
        add_i = 32'h1A10_3000;
        apb.pready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_pre_penable", apb.penable, 1);
        #2;
        rst_ni = 1'b0;
        apb.pready = 1'b1;
        #1;
        chk("rst_mid_psel", apb.psel, 0);
        chk("rst_mid_penable", apb.penable, 0);
        chk("rst_mid_gnt", gnt_o, 0);
        chk("rst_mid_r_valid", r_valid_o, 0);
        chk("rst_mid_paddr", apb.paddr, 0);
        req_i = 1'b0;
        @(negedge clk) rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            cur = n_cyc + 1 + i;
            chk("post_rst_gnt", gnt_o, 0);
            chk("post_rst_r_valid", r_valid_o, 0);
            chk("post_rst_psel", apb.psel, 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
